bouncing_box_renderer: RTL and testbench

- Pixel-rendering stage directly downstream of the video signal generator.
- Consumes the generator's raster position and timing strobes; draws a solid box that moves and bounces off the screen edges.
- Produces 24-bit RGB with hsync/vsync/de delayed to stay aligned with the colour data, for the HDMI/VGA output encoder.
- Box position is updated only during vertical blanking, so a frame never shows the box at two positions (no tearing).

---
 rtl/bouncing_box_renderer_if.sv | 29 ++
 rtl/bouncing_box_renderer.sv | 205 ++++++++++++++++++++
 tb/tb_bouncing_box_renderer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bouncing_box_renderer_if.sv
// Video link around the box renderer: raster position and timing in from the
// generator, coloured pixels and re-aligned timing out to the encoder.
interface bouncing_box_renderer_if #(
    parameter int CX_W = 10,
    parameter int CY_W = 10
);
    logic [CX_W-1:0] i_sx;
    logic [CY_W-1:0] i_sy;
    logic            i_hsync;
    logic            i_vsync;
    logic            i_de;

    logic [7:0]      o_r;
    logic [7:0]      o_g;
    logic [7:0]      o_b;
    logic            o_hsync;
    logic            o_vsync;
    logic            o_de;

    modport master (
        output i_sx, i_sy, i_hsync, i_vsync, i_de,
        input  o_r, o_g, o_b, o_hsync, o_vsync, o_de
    );

    modport slave (
        input  i_sx, i_sy, i_hsync, i_vsync, i_de,
        output o_r, o_g, o_b, o_hsync, o_vsync, o_de
    );
endinterface

// File: rtl/bouncing_box_renderer.sv
// Draws a solid square that bounces around the active area. The box moves only
// on vsync rising edges, and colour and timing leave through a matched 2-stage pipe.
module bouncing_box_renderer #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          CX_W      = 10,
    parameter int          CY_W      = 10,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter logic [23:0] BOX_COLOR = 24'hFF8000,
    parameter logic [23:0] BG_COLOR  = 24'h000040
) (
    input  logic                    i_clk_pxl,
    input  logic                    i_reset_n,
    input  logic                    i_move_en,
    bouncing_box_renderer_if.slave  vid,
    output logic [CX_W-1:0]         o_box_x,
    output logic [CY_W-1:0]         o_box_y,
    output logic                    o_bounce
);

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // One extra bit so position + STEP and position + BOX_SIZE never wrap.
    localparam logic [CX_W:0] X_LIM  = (CX_W + 1)'(H_RES - BOX_SIZE);
    localparam logic [CX_W:0] X_STEP = (CX_W + 1)'(STEP);
    localparam logic [CX_W:0] X_SIZE = (CX_W + 1)'(BOX_SIZE);
    localparam logic [CY_W:0] Y_LIM  = (CY_W + 1)'(V_RES - BOX_SIZE);
    localparam logic [CY_W:0] Y_STEP = (CY_W + 1)'(STEP);
    localparam logic [CY_W:0] Y_SIZE = (CY_W + 1)'(BOX_SIZE);

    logic             r_vs_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic [CX_W-1:0]  r_box_x;
    logic [CY_W-1:0]  r_box_y;
    dir_e             r_dir_x;
    dir_e             r_dir_y;
    logic             r_bounce;

    logic             r_in_box;
    logic             r_de1;
    logic             r_hs1;
    logic             r_vs1;
    logic [23:0]      r_rgb;
    logic             r_de2;
    logic             r_hs2;
    logic             r_vs2;

    logic             w_vs_rise;
    logic             w_move;
    logic [DIV_W-1:0] w_div_next;
    logic [CX_W:0]    w_x_ext;
    logic [CY_W:0]    w_y_ext;
    logic [CX_W:0]    w_x_inc;
    logic [CY_W:0]    w_y_inc;
    logic [CX_W-1:0]  w_x_next;
    logic [CY_W-1:0]  w_y_next;
    dir_e             w_dir_x_next;
    dir_e             w_dir_y_next;
    logic             w_hit_x;
    logic             w_hit_y;
    logic [CX_W:0]    w_sx_ext;
    logic [CY_W:0]    w_sy_ext;
    logic             w_in_box;

    assign w_vs_rise = vid.i_vsync & ~r_vs_q;

    assign w_x_ext = {1'b0, r_box_x};
    assign w_y_ext = {1'b0, r_box_y};
    assign w_x_inc = w_x_ext + X_STEP;
    assign w_y_inc = w_y_ext + Y_STEP;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_div_next = r_div_cnt;
        w_move     = 1'b0;
        if (!i_move_en) begin
            w_div_next = '0;
        end else if (w_vs_rise) begin
            if (r_div_cnt == DIV_LAST) begin
                w_div_next = '0;
                w_move     = 1'b1;
            end else begin
                w_div_next = r_div_cnt + DIV_ONE;
            end
        end
    end

    always_comb begin
        w_x_next     = r_box_x;
        w_dir_x_next = r_dir_x;
        w_hit_x      = 1'b0;
        if (r_dir_x == DIR_POS) begin
            if (w_x_inc >= X_LIM) begin
                w_x_next     = X_LIM[CX_W-1:0];
                w_dir_x_next = DIR_NEG;
                w_hit_x      = 1'b1;
            end else begin
                w_x_next = w_x_inc[CX_W-1:0];
            end
        end else begin
            if (w_x_ext <= X_STEP) begin
                w_x_next     = '0;
                w_dir_x_next = DIR_POS;
                w_hit_x      = 1'b1;
            end else begin
                w_x_next = r_box_x - X_STEP[CX_W-1:0];
            end
        end
    end

    always_comb begin
        w_y_next     = r_box_y;
        w_dir_y_next = r_dir_y;
        w_hit_y      = 1'b0;
        if (r_dir_y == DIR_POS) begin
            if (w_y_inc >= Y_LIM) begin
                w_y_next     = Y_LIM[CY_W-1:0];
                w_dir_y_next = DIR_NEG;
                w_hit_y      = 1'b1;
            end else begin
                w_y_next = w_y_inc[CY_W-1:0];
            end
        end else begin
            if (w_y_ext <= Y_STEP) begin
                w_y_next     = '0;
                w_dir_y_next = DIR_POS;
                w_hit_y      = 1'b1;
            end else begin
                w_y_next = r_box_y - Y_STEP[CY_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vs_q    <= 1'b0;
            r_div_cnt <= '0;
            r_box_x   <= '0;
            r_box_y   <= '0;
            r_dir_x   <= DIR_POS;
            r_dir_y   <= DIR_POS;
            r_bounce  <= 1'b0;
        end else begin
            r_vs_q    <= vid.i_vsync;
            r_div_cnt <= w_div_next;
            r_bounce  <= w_move & (w_hit_x | w_hit_y);
            if (w_move) begin
                r_box_x <= w_x_next;
                r_box_y <= w_y_next;
                r_dir_x <= w_dir_x_next;
                r_dir_y <= w_dir_y_next;
            end
        end
    end

    assign w_sx_ext = {1'b0, vid.i_sx};
    assign w_sy_ext = {1'b0, vid.i_sy};
    assign w_in_box = (w_sx_ext >= w_x_ext) && (w_sx_ext < w_x_ext + X_SIZE) &&
                      (w_sy_ext >= w_y_ext) && (w_sy_ext < w_y_ext + Y_SIZE);

    // Timing strobes travel with the pixel so sync, de and colour stay aligned.
    always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_box <= 1'b0;
            r_de1    <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_rgb    <= '0;
            r_de2    <= 1'b0;
            r_hs2    <= 1'b0;
            r_vs2    <= 1'b0;
        end else begin
            r_in_box <= w_in_box;
            r_de1    <= vid.i_de;
            r_hs1    <= vid.i_hsync;
            r_vs1    <= vid.i_vsync;
            r_rgb    <= r_de1 ? (r_in_box ? BOX_COLOR : BG_COLOR) : 24'h000000;
            r_de2    <= r_de1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
        end
    end

    assign vid.o_r     = r_rgb[23:16];
    assign vid.o_g     = r_rgb[15:8];
    assign vid.o_b     = r_rgb[7:0];
    assign vid.o_de    = r_de2;
    assign vid.o_hsync = r_hs2;
    assign vid.o_vsync = r_vs2;

    assign o_box_x  = r_box_x;
    assign o_box_y  = r_box_y;
    assign o_bounce = r_bounce;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Bench for bouncing_box_renderer: a 640x480 instance and a 128x128 instance
// with FRAME_DIV=3 share one stimulus stream and are checked against a triangle-wave model.
`timescale 1ns/1ps
module tb_bouncing_box_renderer;

    localparam int STEP   = 2;
    localparam int SIZE   = 32;
    localparam int LIM_AX = 640 - SIZE;
    localparam int LIM_AY = 480 - SIZE;
    localparam int LIM_B  = 128 - SIZE;
    localparam int DIV_B  = 3;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic [23:0] rgb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_en;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hs;
    logic       vs;
    logic       de;

    logic [9:0] box_ax, box_ay, box_bx, box_by;
    logic       bounce_a, bounce_b;

    int checks = 0;
    int errors = 0;
    int n_a    = 0;
    int n_b    = 0;
    int div_b  = 0;

    vec_t tbl[10];

    bouncing_box_renderer_if #(.CX_W(10), .CY_W(10)) vid_a ();
    bouncing_box_renderer_if #(.CX_W(10), .CY_W(10)) vid_b ();

    assign vid_a.i_sx    = sx;
    assign vid_a.i_sy    = sy;
    assign vid_a.i_hsync = hs;
    assign vid_a.i_vsync = vs;
    assign vid_a.i_de    = de;
    assign vid_b.i_sx    = sx;
    assign vid_b.i_sy    = sy;
    assign vid_b.i_hsync = hs;
    assign vid_b.i_vsync = vs;
    assign vid_b.i_de    = de;

    bouncing_box_renderer dut_a (
        .i_clk_pxl (clk),
        .i_reset_n (rst_n),
        .i_move_en (move_en),
        .vid       (vid_a),
        .o_box_x   (box_ax),
        .o_box_y   (box_ay),
        .o_bounce  (bounce_a)
    );

    bouncing_box_renderer #(.H_RES(128), .V_RES(128), .FRAME_DIV(DIV_B)) dut_b (
        .i_clk_pxl (clk),
        .i_reset_n (rst_n),
        .i_move_en (move_en),
        .vid       (vid_b),
        .o_box_x   (box_bx),
        .o_box_y   (box_by),
        .o_bounce  (bounce_b)
    );

    always #5 clk = ~clk;

    // Position after n moves: a triangle wave between 0 and lim.
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = (n * STEP) % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    function automatic bit is_hit(input int n, input int lim_x, input int lim_y);
        int px, py;
        px = tri_pos(n, lim_x);
        py = tri_pos(n, lim_y);
        return (n > 0) && (px == 0 || px == lim_x || py == 0 || py == lim_y);
    endfunction

    function automatic logic [23:0] exp_rgb(input logic d, input int x, input int y,
                                            input int bx, input int by);
        if (!d) return 24'h000000;
        return (x >= bx && x < bx + SIZE && y >= by && y < by + SIZE) ? 24'hFF8000 : 24'h000040;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pix(input string name, input logic [23:0] ea, input logic [23:0] eb,
                             input logic d, input logic h, input logic v);
        check({name, "/a"}, 64'({vid_a.o_r, vid_a.o_g, vid_a.o_b, vid_a.o_de, vid_a.o_hsync, vid_a.o_vsync}),
              64'({ea, d, h, v}));
        check({name, "/b"}, 64'({vid_b.o_r, vid_b.o_g, vid_b.o_b, vid_b.o_de, vid_b.o_hsync, vid_b.o_vsync}),
              64'({eb, d, h, v}));
    endtask

    task automatic check_pos(input string name);
        check({name, "/pos_a"}, 64'({box_ax, box_ay}),
              64'({10'(tri_pos(n_a, LIM_AX)), 10'(tri_pos(n_a, LIM_AY))}));
        check({name, "/pos_b"}, 64'({box_bx, box_by}),
              64'({10'(tri_pos(n_b, LIM_B)), 10'(tri_pos(n_b, LIM_B))}));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/out_a"}, 64'({vid_a.o_r, vid_a.o_g, vid_a.o_b, vid_a.o_de, vid_a.o_hsync,
                                     vid_a.o_vsync, box_ax, box_ay, bounce_a}), 64'd0);
        check({name, "/out_b"}, 64'({vid_b.o_r, vid_b.o_g, vid_b.o_b, vid_b.o_de, vid_b.o_hsync,
                                     vid_b.o_vsync, box_bx, box_by, bounce_b}), 64'd0);
    endtask

    // One vsync rising edge held high for `hold` cycles, with move_en changing on the same cycle.
    task automatic vsync_edge(input int hold, input bit en);
        bit exp_ba, exp_bb;
        int cnt_a, cnt_b;
        exp_ba = 1'b0;
        exp_bb = 1'b0;
        cnt_a  = 0;
        cnt_b  = 0;
        if (en) begin
            n_a++;
            exp_ba = is_hit(n_a, LIM_AX, LIM_AY);
        end
        if (!en) begin
            div_b = 0;
        end else if (div_b == DIV_B - 1) begin
            div_b = 0;
            n_b++;
            exp_bb = is_hit(n_b, LIM_B, LIM_B);
        end else begin
            div_b++;
        end
        @(negedge clk);
        move_en = en;
        vs      = 1'b1;
        for (int c = 0; c < hold + 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("bounce_first/a", 64'(bounce_a), 64'(exp_ba));
                check("bounce_first/b", 64'(bounce_b), 64'(exp_bb));
                check_pos("edge");
            end
            cnt_a += int'(bounce_a);
            cnt_b += int'(bounce_b);
            if (c == hold - 1) vs = 1'b0;
        end
        check("bounce_count/a", 64'(cnt_a), 64'(exp_ba));
        check("bounce_count/b", 64'(cnt_b), 64'(exp_bb));
        check_pos("after_hold");
    endtask

    task automatic probe_pixel();
        int ax, ay, bx, by, tx, ty;
        logic d, h;
        ax = tri_pos(n_a, LIM_AX);
        ay = tri_pos(n_a, LIM_AY);
        bx = tri_pos(n_b, LIM_B);
        by = tri_pos(n_b, LIM_B);
        tx = ax + int'($urandom_range(0, 40)) - 4;
        ty = ay + int'($urandom_range(0, 40)) - 4;
        if (tx < 0) tx = 0;
        if (ty < 0) ty = 0;
        if ($urandom_range(0, 3) == 0) begin
            tx = int'($urandom_range(0, 639));
            ty = int'($urandom_range(0, 479));
        end
        d = ($urandom_range(0, 4) != 0);
        h = 1'($urandom_range(0, 1));
        @(negedge clk);
        sx = 10'(tx);
        sy = 10'(ty);
        de = d;
        hs = h;
        @(negedge clk);
        sx = '0;
        sy = '0;
        de = 1'b0;
        hs = 1'b0;
        @(negedge clk);
        check_pix("probe", exp_rgb(d, tx, ty, ax, ay), exp_rgb(d, tx, ty, bx, by), d, h, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        move_en = 1'b0;
        sx      = '0;
        sy      = '0;
        hs      = 1'b0;
        vs      = 1'b0;
        de      = 1'b0;

        // Both boxes sit at (0,0) while these run, covering pixels 0..31.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 10'd5,   10'd5,   24'hFF8000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 10'd40,  10'd5,   24'h000040};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 10'd5,   10'd5,   24'h000000};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 10'd31,  10'd31,  24'hFF8000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 10'd32,  10'd31,  24'h000040};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 10'd31,  10'd32,  24'h000040};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 10'd0,   10'd0,   24'h000000};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 10'd0,   10'd0,   24'hFF8000};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 10'd639, 10'd479, 24'h000040};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 10'd10,  10'd10,  24'h000000};

        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2)
                check_pix($sformatf("vec%0d", i - 2), tbl[i - 2].rgb, tbl[i - 2].rgb,
                          tbl[i - 2].de, tbl[i - 2].hs, tbl[i - 2].vs);
            if (i < 10) begin
                de = tbl[i].de;
                hs = tbl[i].hs;
                vs = tbl[i].vs;
                sx = tbl[i].sx;
                sy = tbl[i].sy;
            end else begin
                de = 1'b0;
                hs = 1'b0;
                vs = 1'b0;
                sx = '0;
                sy = '0;
            end
        end

        for (int i = 0; i < 6; i++) vsync_edge(2, 1'b1);
        check("six_edges/a", 64'({box_ax, box_ay}), 64'({10'd12, 10'd12}));
        check("six_edges/b", 64'({box_bx, box_by}), 64'({10'd4, 10'd4}));

        // Reset mid-frame with a box pixel in flight.
        @(negedge clk);
        de = 1'b1;
        hs = 1'b1;
        sx = 10'd13;
        sy = 10'd13;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        n_a   = 0;
        n_b   = 0;
        div_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        de    = 1'b0;
        hs    = 1'b0;
        sx    = '0;
        sy    = '0;
        check_pos("post_reset");
        probe_pixel();

        // Long continuous run: right-wall bounce at 606->608->606 and both corners of the small screen.
        for (int i = 0; i < 305; i++) begin
            vsync_edge(2 + (i % 2), 1'b1);
            if (i % 4 == 0) probe_pixel();
        end
        check("right_wall_return/a", 64'(box_ax), 64'(10'd606));

        // Disable on the same cycle as a vsync rise, then hold disabled across more edges.
        for (int i = 0; i < 5; i++) vsync_edge(2, 1'b0);
        probe_pixel();

        for (int i = 0; i < 150; i++) begin
            vsync_edge(int'($urandom_range(1, 4)), ($urandom_range(0, 7) != 0));
            probe_pixel();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
